// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the register file with scoreboard.
//   DEF_DATA_W / DEF_ADDR_W : default register width and address width
//   ZEROWORD                : all-zero word at the default width
//   RST_ENABLE              : level of 'reset' that clears state
//   REGNUM                  : register count at the default address width
package regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam logic [DEF_DATA_W-1:0] ZEROWORD = '0;
   localparam logic RST_ENABLE = 1'b1;
   localparam int REGNUM = 2 ** DEF_ADDR_W;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for the register file.
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   wr_en, wr_addr         : writeback (clears pending)
//   issue, issue_dst       : issue (sets pending; wins over a same-register clear)
//   ra                     : packed read addresses, NUM_RD ports
//   rpend                  : pending bit of each read port's register
//   wb_err                 : sticky, writeback to a non-pending nonzero register
//   pend_cnt               : registered count of pending registers
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     issue,
   input  logic [ADDR_W-1:0]        issue_dst,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD-1:0]        rpend,
   output logic                     wb_err,
   output logic [ADDR_W:0]          pend_cnt
);

   localparam int NREG = 2 ** ADDR_W;

   logic [NREG-1:0] pend;
   logic [NREG-1:0] pend_nxt;
   logic            wr_vld;
   logic            iss_vld;
   logic            inc;
   logic            dec;

   assign wr_vld  = wr_en && (wr_addr != '0);
   assign iss_vld = issue && (issue_dst != '0);

   // Count tracks the vector incrementally: a set only counts if the bit was
   // clear, a clear only counts if the bit was set and not re-issued.
   assign inc = iss_vld && !pend[issue_dst];
   assign dec = wr_vld && pend[wr_addr] && !(iss_vld && (issue_dst == wr_addr));

   always_comb begin
      pend_nxt = pend;
      if (wr_vld)
         pend_nxt[wr_addr] = 1'b0;
      if (iss_vld)
         pend_nxt[issue_dst] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset == RST_ENABLE) begin
         pend     <= '0;
         wb_err   <= 1'b0;
         pend_cnt <= '0;
      end else begin
         pend     <= pend_nxt;
         pend_cnt <= pend_cnt + (ADDR_W+1)'(inc) - (ADDR_W+1)'(dec);
         if (wr_vld && !pend[wr_addr])
            wb_err <= 1'b1;
      end
   end

   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_lookup
         assign rpend[k] = pend[ra[k*ADDR_W +: ADDR_W]];
      end
   endgenerate

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with integrated scoreboard.
// NUM_RD combinational read ports, one clocked writeback port, r0 reads zero.
// Optional macro REGFILE_BYPASS_EN: a same-cycle writeback forwards WD3 to
// matching read ports and forces their RRdy high.
// Ports:
//   clock, reset      : clock, synchronous active-high reset
//   RegWrite, A3, WD3 : writeback enable / address / data
//   Issue, IssueDst   : mark IssueDst pending
//   RA, RD            : packed read addresses / data, port k at slice k
//   RRdy              : per-port data valid (not pending, or bypassed)
//   WbErr             : sticky writeback-to-non-pending error
//   PendCnt           : number of pending registers
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     RegWrite,
   input  logic [ADDR_W-1:0]        A3,
   input  logic [DATA_W-1:0]        WD3,
   input  logic                     Issue,
   input  logic [ADDR_W-1:0]        IssueDst,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] RD,
   output logic [NUM_RD-1:0]        RRdy,
   output logic                     WbErr,
   output logic [ADDR_W:0]          PendCnt
);

   localparam int NREG = 2 ** ADDR_W;

`ifdef REGFILE_BYPASS_EN
   localparam logic BYPASS = 1'b1;
`else
   localparam logic BYPASS = 1'b0;
`endif

   logic [DATA_W-1:0] regs [NREG];
   logic [NUM_RD-1:0] rpend;
   logic              in_reset;

   assign in_reset = (reset == RST_ENABLE);

   always_ff @(posedge clock) begin
      if (in_reset) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= '0;
      end else if (RegWrite && (A3 != '0)) begin
         regs[A3] <= WD3;
      end
   end

   regfile_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clock     (clock),
      .reset     (reset),
      .wr_en     (RegWrite),
      .wr_addr   (A3),
      .issue     (Issue),
      .issue_dst (IssueDst),
      .ra        (RA),
      .rpend     (rpend),
      .wb_err    (WbErr),
      .pend_cnt  (PendCnt)
   );

   genvar k;
   generate
      for (k = 0; k < NUM_RD; k++) begin : g_rd
         logic [ADDR_W-1:0] ra_k;
         logic              zero_k;
         logic              byp_k;

         assign ra_k   = RA[k*ADDR_W +: ADDR_W];
         assign zero_k = in_reset || (ra_k == '0);
         assign byp_k  = BYPASS && RegWrite && (A3 == ra_k);

         assign RD[k*DATA_W +: DATA_W] = zero_k ? '0 :
                                         byp_k  ? WD3 : regs[ra_k];
         assign RRdy[k] = zero_k || byp_k || !rpend[k];
      end
   endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic              clock = 1'b0;
   logic              reset;
   logic              RegWrite;
   logic [AW-1:0]     A3;
   logic [DW-1:0]     WD3;
   logic              Issue;
   logic [AW-1:0]     IssueDst;
   logic [NR*AW-1:0]  RA;
   logic [NR*DW-1:0]  RD;
   logic [NR-1:0]     RRdy;
   logic              WbErr;
   logic [AW:0]       PendCnt;

   int total = 0;
   int bad   = 0;

   regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clock    (clock),
      .reset    (reset),
      .RegWrite (RegWrite),
      .A3       (A3),
      .WD3      (WD3),
      .Issue    (Issue),
      .IssueDst (IssueDst),
      .RA       (RA),
      .RD       (RD),
      .RRdy     (RRdy),
      .WbErr    (WbErr),
      .PendCnt  (PendCnt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // inputs change 1ns after a rising edge; outputs are sampled 1ns later
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic rd_set(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
      RA = {a1, a0};
      #1;
   endtask

   task automatic idle();
      RegWrite = 1'b0; A3 = '0; WD3 = '0; Issue = 1'b0; IssueDst = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      idle();
      RA    = '0;
      reset = 1'b1;
      tick();
      // during reset, every port reads zero/ready even for a nonzero address
      rd_set(5'd4, 5'd31);
      chk("rst_rd", RD, 64'h0);
      chk("rst_rrdy", RRdy, 2'b11);
      tick();
      reset = 1'b0;
      tick();

      for (int a = 0; a < 32; a++) begin
         rd_set(AW'(a), AW'(31 - a));
         chk("init_rd", RD, 64'h0);
         chk("init_rrdy", RRdy, 2'b11);
      end
      chk("init_pcnt", PendCnt, 0);
      chk("init_wberr", WbErr, 0);

      // plain write r5, read next cycle on port 1 (r5 not pending -> WbErr)
      RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
      tick();
      idle();
      rd_set(5'd0, 5'd5);
      chk("wr5_rd", RD, {32'hDEADBEEF, 32'h0});
      chk("wr5_rrdy", RRdy, 2'b11);
      chk("wr5_wberr", WbErr, 1);

      // writes to r0 are dropped
      RegWrite = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF;
      tick();
      idle();
      rd_set(5'd0, 5'd0);
      chk("wr0_rd", RD, 64'h0);
      chk("wr0_rrdy", RRdy, 2'b11);

      do_reset();
      rd_set(5'd5, 5'd5);
      chk("rst2_rd", RD, 64'h0);
      chk("rst2_wberr", WbErr, 0);

      // issue r7, then writeback it
      Issue = 1'b1; IssueDst = 5'd7;
      tick();
      idle();
      rd_set(5'd7, 5'd0);
      chk("iss7_rrdy", RRdy, 2'b10);
      chk("iss7_pcnt", PendCnt, 1);
      RegWrite = 1'b1; A3 = 5'd7; WD3 = 32'h12345678;
      rd_set(5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
      chk("wb7_same_rd", RD, {32'h12345678, 32'h12345678});
      chk("wb7_same_rrdy", RRdy, 2'b11);
`else
      chk("wb7_same_rd", RD, 64'h0);
      chk("wb7_same_rrdy", RRdy, 2'b00);
`endif
      tick();
      idle();
      #1;
      chk("wb7_next_rd", RD, {32'h12345678, 32'h12345678});
      chk("wb7_next_rrdy", RRdy, 2'b11);
      chk("wb7_pcnt", PendCnt, 0);
      chk("wb7_wberr", WbErr, 0);

      // issue + writeback r3 together: data lands, stays pending
      Issue = 1'b1; IssueDst = 5'd3; RegWrite = 1'b1; A3 = 5'd3; WD3 = 32'hA5;
      tick();
      idle();
      rd_set(5'd3, 5'd0);
      chk("iw3_rd", RD, {32'h0, 32'hA5});
      chk("iw3_rrdy", RRdy, 2'b10);
      chk("iw3_pcnt", PendCnt, 1);
      chk("iw3_wberr", WbErr, 1);
      // again while pending: set and clear on same register nets zero
      Issue = 1'b1; IssueDst = 5'd3; RegWrite = 1'b1; A3 = 5'd3; WD3 = 32'h5A;
      tick();
      idle();
      rd_set(5'd0, 5'd3);
      chk("iw3b_rd", RD, {32'h5A, 32'h0});
      chk("iw3b_rrdy", RRdy, 2'b01);
      chk("iw3b_pcnt", PendCnt, 1);

      // writeback r9 with no issue -> sticky WbErr
      do_reset();
      chk("rst3_wberr", WbErr, 0);
      chk("rst3_pcnt", PendCnt, 0);
      RegWrite = 1'b1; A3 = 5'd9; WD3 = 32'h99;
      rd_set(5'd9, 5'd9);
      chk("wb9_same_wberr", WbErr, 0);
      tick();
      idle();
      rd_set(5'd9, 5'd0);
      chk("wb9_wberr", WbErr, 1);
      chk("wb9_rd", RD, {32'h0, 32'h99});
      tick();
      tick();
      chk("wb9_sticky", WbErr, 1);

      // three issues, then reset discards them
      do_reset();
      Issue = 1'b1; IssueDst = 5'd1; tick();
      IssueDst = 5'd2; tick();
      IssueDst = 5'd3; tick();
      idle();
      rd_set(5'd1, 5'd2);
      chk("iss3_pcnt", PendCnt, 3);
      chk("iss3_rrdy", RRdy, 2'b00);
      // issue during reset is ignored
      Issue = 1'b1; IssueDst = 5'd4;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      rd_set(5'd1, 5'd4);
      chk("post_rst_pcnt", PendCnt, 0);
      chk("post_rst_rrdy", RRdy, 2'b11);
      chk("post_rst_wberr", WbErr, 0);
      rd_set(5'd9, 5'd3);
      chk("post_rst_rd", RD, 64'h0);
      RegWrite = 1'b1; A3 = 5'd2; WD3 = 32'h22;
      tick();
      idle();
      rd_set(5'd2, 5'd2);
      chk("late_wb_wberr", WbErr, 1);
      chk("late_wb_rd", RD, {32'h22, 32'h22});
      chk("late_wb_pcnt", PendCnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
